// File: rtl/common_pkg.sv
// Core-wide reset and filler constants shared by the pipeline stages.
package common_pkg;

    localparam logic [63:0] PC_RESET  = 64'h8000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : common_pkg

// File: rtl/fetch_stage_pkg.sv
// Fetch/decode pipeline types: fetch FSM states and the fetch/decode register payload.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2,
        HALT    = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] raw_instr;
        logic            except;
    } fetch_data_t;

endpackage : fetch_stage_pkg

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction bus and fills the
// fetch/decode register, absorbing one response in a holding buffer during decode stall.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] PC_RESET  = common_pkg::PC_RESET,
    parameter logic [ILEN-1:0] NOP_INSTR = common_pkg::NOP_INSTR
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    output logic            ireq_valid_o,
    output logic [XLEN-1:0] ireq_addr_o,
    input  logic            iresp_data_ok_i,
    input  logic [ILEN-1:0] iresp_data_i,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            d_valid_o,
    output logic [XLEN-1:0] d_pc_o,
    output logic [ILEN-1:0] d_raw_instr_o,
    output logic            d_except_o
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic            req_q, req_d;
    fetch_data_t     dec_q, dec_d;
    fetch_data_t     buf_q, buf_d;

    logic [XLEN-1:0] pc_next;
    logic            misaligned;
    logic            resp;

    assign pc_next    = pc_q + XLEN'(4);
    assign misaligned = |pc_q[1:0];
    assign resp       = req_q & iresp_data_ok_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FETCH;
            pc_q    <= PC_RESET;
            tgt_q   <= '0;
            req_q   <= 1'b0;
            dec_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            req_q   <= req_d;
            dec_q   <= dec_d;
            buf_q   <= buf_d;
        end
    end

    // Redirect takes priority over stall in every state.
    always_comb begin
        state_d = state_q;
        if (redirect_valid_i) begin
            state_d = (req_q && !iresp_data_ok_i) ? DISCARD : FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (misaligned) begin
                        if (!stall_i) state_d = HALT;
                    end else if (resp && stall_i) begin
                        state_d = HOLD;
                    end
                end
                HOLD:    if (!stall_i) state_d = FETCH;
                DISCARD: if (resp) state_d = FETCH;
                HALT:    state_d = HALT;
                default: state_d = FETCH;
            endcase
        end
    end

    // Request, PC, holding buffer and fetch/decode register updates.
    always_comb begin
        pc_d  = pc_q;
        tgt_d = tgt_q;
        req_d = req_q;
        dec_d = dec_q;
        buf_d = buf_q;
        if (redirect_valid_i) begin
            dec_d.valid  = 1'b0;
            dec_d.except = 1'b0;
            buf_d.valid  = 1'b0;
            if (req_q && !iresp_data_ok_i) begin
                tgt_d = redirect_pc_i;
            end else begin
                pc_d  = redirect_pc_i;
                req_d = ~|redirect_pc_i[1:0];
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (misaligned) begin
                        req_d = 1'b0;
                        if (!stall_i) begin
                            dec_d = '{valid: 1'b1, pc: pc_q, raw_instr: NOP_INSTR, except: 1'b1};
                        end
                    end else if (resp) begin
                        if (!stall_i) begin
                            dec_d = '{valid: 1'b1, pc: pc_q, raw_instr: iresp_data_i, except: 1'b0};
                            pc_d  = pc_next;
                            req_d = 1'b1;
                        end else begin
                            buf_d = '{valid: 1'b1, pc: pc_q, raw_instr: iresp_data_i, except: 1'b0};
                            req_d = 1'b0;
                        end
                    end else begin
                        req_d = 1'b1;
                        if (!stall_i) dec_d.valid = 1'b0;
                    end
                end
                HOLD: begin
                    req_d = 1'b0;
                    if (!stall_i) begin
                        dec_d       = buf_q;
                        buf_d.valid = 1'b0;
                        pc_d        = pc_next;
                        req_d       = 1'b1;
                    end
                end
                DISCARD: begin
                    if (resp) begin
                        pc_d  = tgt_q;
                        req_d = ~|tgt_q[1:0];
                    end
                end
                HALT: begin
                    req_d = 1'b0;
                    if (!stall_i) dec_d.valid = 1'b0;
                end
                default: req_d = 1'b0;
            endcase
        end
    end

    assign ireq_valid_o  = req_q;
    assign ireq_addr_o   = pc_q;
    assign d_valid_o     = dec_q.valid;
    assign d_pc_o        = dec_q.pc;
    assign d_raw_instr_o = dec_q.raw_instr;
    assign d_except_o    = dec_q.except;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by a randomized
// bus/stall/redirect run checked against an instruction-stream reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        ok;
    logic [31:0] data;
    logic        stall;
    logic        redir;
    logic [63:0] rpc;
    logic        d_valid;
    logic [63:0] d_pc;
    logic [31:0] d_raw;
    logic        d_except;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state for the random phase.
    logic [63:0] exp_fetch, exp_cons, pend_addr, a;
    logic        pend, discard;
    int          lat, consumed;

    fetch_stage dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .ireq_valid_o    (ireq_valid),
        .ireq_addr_o     (ireq_addr),
        .iresp_data_ok_i (ok),
        .iresp_data_i    (data),
        .stall_i         (stall),
        .redirect_valid_i(redir),
        .redirect_pc_i   (rpc),
        .d_valid_o       (d_valid),
        .d_pc_o          (d_pc),
        .d_raw_instr_o   (d_raw),
        .d_except_o      (d_except)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] addr);
        return addr[31:0] ^ {addr[15:0], addr[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input int cycles, input logic [31:0] w);
        repeat (cycles) tick();
        ok   = 1'b1;
        data = w;
        tick();
        ok   = 1'b0;
    endtask

    task automatic chk_d(input string tag, input logic [63:0] pc, input logic [31:0] w,
                         input logic exc);
        chk1({tag, "_dv"}, d_valid, 1'b1);
        chk({tag, "_dpc"}, d_pc, pc);
        chk({tag, "_draw"}, 64'(d_raw), 64'(w));
        chk1({tag, "_dexc"}, d_except, exc);
    endtask

    task automatic chk_req(input string tag, input logic [63:0] addr);
        chk1({tag, "_rv"}, ireq_valid, 1'b1);
        chk({tag, "_ra"}, ireq_addr, addr);
    endtask

    initial begin
        rst_n = 1'b0; ok = 1'b0; data = '0; stall = 1'b0; redir = 1'b0; rpc = '0;
        #12;
        chk1("rst_rv", ireq_valid, 1'b0);
        chk1("rst_dv", d_valid, 1'b0);
        chk("rst_dpc", d_pc, 64'h0);
        chk("rst_draw", 64'(d_raw), 64'h0);
        chk1("rst_dexc", d_except, 1'b0);
        chk("rst_ra", ireq_addr, 64'h8000_0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk1("rel_rv", ireq_valid, 1'b0);
        tick();

        // 1: sequential fetch, response two cycles after each request
        for (int i = 0; i < 3; i++) begin
            a = 64'h8000_0000 + 64'(4 * i);
            chk_req("t1_req", a);
            tick();
            chk1("t1_bubble", d_valid, 1'b0);
            chk_req("t1_held", a);
            respond(1, instr_of(a));
            chk_d("t1", a, instr_of(a), 1'b0);
        end

        // 2: stall on response -> HOLD, buffered word released when stall drops
        chk_req("t2_req", 64'h8000_000C);
        stall = 1'b1; ok = 1'b1; data = instr_of(64'h8000_000C);
        tick();
        ok = 1'b0;
        chk1("t2_hold_rv", ireq_valid, 1'b0);
        chk_d("t2_hold", 64'h8000_0008, instr_of(64'h8000_0008), 1'b0);
        tick(); tick();
        chk1("t2_hold2_rv", ireq_valid, 1'b0);
        chk_d("t2_hold2", 64'h8000_0008, instr_of(64'h8000_0008), 1'b0);
        stall = 1'b0;
        tick();
        chk_d("t2_rel", 64'h8000_000C, instr_of(64'h8000_000C), 1'b0);
        chk_req("t2_next", 64'h8000_0010);

        // 3: redirect with request outstanding -> old request completes, word dropped
        redir = 1'b1; rpc = 64'h8000_0100;
        tick();
        redir = 1'b0;
        chk_req("t3_disc", 64'h8000_0010);
        chk1("t3_dv", d_valid, 1'b0);
        tick();
        chk_req("t3_disc2", 64'h8000_0010);
        ok = 1'b1; data = 32'hDEAD_BEEF;
        tick();
        ok = 1'b0;
        chk_req("t3_tgt", 64'h8000_0100);
        chk1("t3_dv2", d_valid, 1'b0);
        respond(1, instr_of(64'h8000_0100));
        chk_d("t3_word", 64'h8000_0100, instr_of(64'h8000_0100), 1'b0);

        // 4: redirect + data_ok + stall in one cycle -> redirect wins, buffer empty
        ok = 1'b1; data = 32'hBAD0_0001; stall = 1'b1; redir = 1'b1; rpc = 64'h8000_0180;
        tick();
        ok = 1'b0; redir = 1'b0;
        chk_req("t4_tgt", 64'h8000_0180);
        chk1("t4_dv", d_valid, 1'b0);
        stall = 1'b0;
        respond(0, instr_of(64'h8000_0180));
        chk_d("t4_word", 64'h8000_0180, instr_of(64'h8000_0180), 1'b0);

        // 5: misaligned target -> exception entry, then idle until redirected
        ok = 1'b1; data = 32'hBAD0_0002; redir = 1'b1; rpc = 64'h8000_0102;
        tick();
        ok = 1'b0; redir = 1'b0;
        chk1("t5_rv", ireq_valid, 1'b0);
        chk1("t5_dv", d_valid, 1'b0);
        tick();
        chk_d("t5_exc", 64'h8000_0102, 32'h0000_0013, 1'b1);
        chk1("t5_rv2", ireq_valid, 1'b0);
        tick();
        chk1("t5_dv_clr", d_valid, 1'b0);
        repeat (3) tick();
        chk1("t5_idle_rv", ireq_valid, 1'b0);
        redir = 1'b1; rpc = 64'h8000_0200;
        tick();
        redir = 1'b0;
        chk_req("t5_resume", 64'h8000_0200);
        chk1("t5_dexc", d_except, 1'b0);

        // 6: asynchronous reset mid-request and mid-HOLD
        #2 rst_n = 1'b0;
        #1;
        chk1("t6a_rv", ireq_valid, 1'b0);
        chk1("t6a_dv", d_valid, 1'b0);
        chk("t6a_dpc", d_pc, 64'h0);
        chk("t6a_draw", 64'(d_raw), 64'h0);
        chk1("t6a_dexc", d_except, 1'b0);
        chk("t6a_ra", ireq_addr, 64'h8000_0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        chk_req("t6a_first", 64'h8000_0000);
        stall = 1'b1; ok = 1'b1; data = instr_of(64'h8000_0000);
        tick();
        ok = 1'b0;
        chk1("t6b_hold_rv", ireq_valid, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk1("t6b_rv", ireq_valid, 1'b0);
        chk1("t6b_dv", d_valid, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1; stall = 1'b0;
        tick();
        chk_req("t6b_first", 64'h8000_0000);
        chk1("t6b_dv2", d_valid, 1'b0);

        // PC wrap at the top of the address space
        ok = 1'b1; data = 32'hBAD0_0003; redir = 1'b1; rpc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        ok = 1'b0; redir = 1'b0;
        chk_req("wrap_req", 64'hFFFF_FFFF_FFFF_FFFC);
        respond(0, instr_of(64'hFFFF_FFFF_FFFF_FFFC));
        chk_d("wrap", 64'hFFFF_FFFF_FFFF_FFFC, instr_of(64'hFFFF_FFFF_FFFF_FFFC), 1'b0);
        chk_req("wrap_next", 64'h0);

        // Random phase: decode must see the program-order stream with no loss or duplicates.
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_fetch = 64'h8000_0000; exp_cons = 64'h8000_0000;
        pend = 1'b0; discard = 1'b0; lat = 0; consumed = 0; pend_addr = '0;
        for (int c = 0; c < 3000; c++) begin
            if (pend) begin
                chk1("rnd_hold_rv", ireq_valid, 1'b1);
                chk("rnd_hold_ra", ireq_addr, pend_addr);
            end else if (ireq_valid) begin
                chk("rnd_new_ra", ireq_addr, exp_fetch);
                pend_addr = ireq_addr;
                lat = int'($urandom_range(0, 3));
            end
            stall = ($urandom_range(0, 3) == 0);
            redir = ($urandom_range(0, 19) == 0);
            rpc   = 64'h8000_0000 + (64'($urandom_range(0, 255)) << 2);
            ok    = ireq_valid && (lat == 0);
            data  = instr_of(ireq_addr);
            if (ireq_valid && lat > 0) lat--;
            if (d_valid && !stall && !redir) begin
                chk("rnd_dpc", d_pc, exp_cons);
                chk("rnd_draw", 64'(d_raw), 64'(instr_of(exp_cons)));
                chk1("rnd_dexc", d_except, 1'b0);
                exp_cons = exp_cons + 64'd4;
                consumed++;
            end
            if (redir) begin
                exp_fetch = rpc;
                exp_cons  = rpc;
                discard   = ireq_valid && !ok;
            end else if (ok) begin
                if (discard) discard = 1'b0;
                else         exp_fetch = exp_fetch + 64'd4;
            end
            pend = ireq_valid && !ok;
            tick();
        end
        ok = 1'b0; stall = 1'b0; redir = 1'b0;
        chk1("rnd_progress", consumed > 200, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_fetch_stage
